// File: rtl/mem_pkg.sv
// Shared types and helpers for the multicycle MIPS memory responder.
package mem_pkg;

  // Responder state: idle, inserting wait states, or presenting the response
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } memst_t;

  // Captured operation; OP_NONE marks a rejected read+write request
  localparam logic [1:0] OP_NONE = 2'd0;
  localparam logic [1:0] OP_RD   = 2'd1;
  localparam logic [1:0] OP_WR   = 2'd2;

  // Byte address to word index; caller keeps the low log2(DEPTH) bits
  // and treats any remaining nonzero bits as out of range
  function automatic logic [31:0] word_index(input logic [31:0] addr);
    return {2'b00, addr[31:2]};
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between the control FSM (master) and the memory
// responder (slave).
interface mem_responder_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              MemRead;
  logic              MemWrite;
  logic [ADDR_W-1:0] Addr;
  logic [DATA_W-1:0] WriteData;
  logic [DATA_W-1:0] ReadData;
  logic              MemReady;
  logic              MemBusy;
  logic              MemErr;

  modport master (
    output MemRead, MemWrite, Addr, WriteData,
    input  ReadData, MemReady, MemBusy, MemErr
  );

  modport slave (
    input  MemRead, MemWrite, Addr, WriteData,
    output ReadData, MemReady, MemBusy, MemErr
  );

endinterface

// File: rtl/mem_array.sv
// Single-port synchronous RAM, DEPTH x DATA_W, read-first, contents not reset.
module mem_array #(
  parameter int DEPTH  = 256,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [DATA_W-1:0]        wdata_i,
  output logic [DATA_W-1:0]        rdata_o
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write the addressed word when enabled and register the old contents out
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[addr_i] <= wdata_i;
    end
    rdata_o <= mem[addr_i];
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the multicycle MIPS core. Accepts one request at
// a time in IDLE, inserts WAIT_CYCLES wait states, then completes with a
// one-cycle MemReady pulse. All bus outputs are registered from the state, so
// they appear one cycle after the state that produces them; ReadData is loaded
// together with MemReady so it is valid whenever MemReady is seen.
// Only the low 32 address bits are examined (ADDR_W <= 32 expected).
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input logic            clk,
  input logic            rst,
  mem_responder_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [3:0] LAST_WAIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  memst_t            state_q;
  logic [3:0]        cnt_q;
  logic [1:0]        op_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic              misalign_q;
  logic              outOfRange_q;
  logic [DATA_W-1:0] readData_q;
  logic              ready_q;
  logic              busy_q;
  logic              err_q;

  logic [ADDR_W-1:0] addrIn;
  logic [31:0]       wordIn;
  logic              reqValid;
  logic              reqMis;
  logic              reqOor;
  logic [1:0]        reqOp;
  logic              lastWait;
  logic              capErr;
  logic              ramWe;
  logic [IDX_W-1:0]  ramIdx;
  logic [DATA_W-1:0] ramWdata;
  logic [DATA_W-1:0] ramRdata;

  // Decode the live request: operation, alignment and range of the address
  always_comb begin
    addrIn   = bus.Addr;
    wordIn   = word_index(32'(addrIn));
    reqValid = bus.MemRead | bus.MemWrite;
    reqMis   = (addrIn[1:0] != 2'b00);
    reqOor   = ((wordIn >> IDX_W) != 32'd0);
    reqOp    = OP_NONE;
    if (bus.MemRead && !bus.MemWrite) begin
      reqOp = OP_RD;
    end else if (bus.MemWrite && !bus.MemRead) begin
      reqOp = OP_WR;
    end
  end

  // RAM port: driven from the live request at acceptance (zero wait states),
  // otherwise from the captured request so later input changes are ignored
  always_comb begin
    lastWait = (state_q == WAIT) && (cnt_q == LAST_WAIT);
    capErr   = (op_q == OP_NONE) | misalign_q | outOfRange_q;
    ramIdx   = idx_q;
    ramWdata = wdata_q;
    ramWe    = lastWait && (op_q == OP_WR) && !capErr;
    if (state_q == IDLE) begin
      ramIdx   = wordIn[IDX_W-1:0];
      ramWdata = bus.WriteData;
      ramWe    = (WAIT_CYCLES == 0) && (reqOp == OP_WR) && !reqMis && !reqOor;
    end
  end

  mem_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_array (
    .clk     (clk),
    .we_i    (ramWe),
    .addr_i  (ramIdx),
    .wdata_i (ramWdata),
    .rdata_o (ramRdata)
  );

  // Transaction FSM with request capture, wait counter and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      op_q         <= OP_NONE;
      idx_q        <= '0;
      wdata_q      <= '0;
      misalign_q   <= 1'b0;
      outOfRange_q <= 1'b0;
      readData_q   <= '0;
      ready_q      <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      ready_q <= (state_q == RESP);
      busy_q  <= (state_q != IDLE);
      err_q   <= (state_q == RESP) && capErr;
      case (state_q)
        IDLE: begin
          if (reqValid) begin
            op_q         <= reqOp;
            idx_q        <= wordIn[IDX_W-1:0];
            wdata_q      <= bus.WriteData;
            misalign_q   <= reqMis;
            outOfRange_q <= reqOor;
            cnt_q        <= '0;
            state_q      <= (WAIT_CYCLES == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == LAST_WAIT) begin
            cnt_q   <= '0;
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        RESP: begin
          if ((op_q == OP_RD) && !misalign_q) begin
            readData_q <= outOfRange_q ? '0 : ramRdata;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ReadData = readData_q;
  assign bus.MemReady = ready_q;
  assign bus.MemBusy  = busy_q;
  assign bus.MemErr   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: one instance with two wait states and
// one with none. Each transaction pushes its expected response; the response
// is popped and compared when MemReady is seen.
module tb_mem_responder;

  localparam int WC_A = 2;
  localparam int WC_B = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic        chkData;
    int          lat;
  } expect_t;

  logic clk;
  logic rst;
  int   curSel;
  int   checks;
  int   errors;
  expect_t sbQ[$];

  logic        obsReady;
  logic        obsBusy;
  logic        obsErr;
  logic [31:0] obsData;

  mem_responder_if #(.ADDR_W(32), .DATA_W(32)) busA ();
  mem_responder_if #(.ADDR_W(32), .DATA_W(32)) busB ();

  mem_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH(256), .WAIT_CYCLES(WC_A)) dutA (
    .clk (clk),
    .rst (rst),
    .bus (busA)
  );

  mem_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH(256), .WAIT_CYCLES(WC_B)) dutB (
    .clk (clk),
    .rst (rst),
    .bus (busB)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Observe whichever instance the current test targets
  always_comb begin
    if (curSel == 0) begin
      obsReady = busA.MemReady;
      obsBusy  = busA.MemBusy;
      obsErr   = busA.MemErr;
      obsData  = busA.ReadData;
    end else begin
      obsReady = busB.MemReady;
      obsBusy  = busB.MemBusy;
      obsErr   = busB.MemErr;
      obsData  = busB.ReadData;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    if (curSel == 0) begin
      busA.MemRead = rd; busA.MemWrite = wr; busA.Addr = addr; busA.WriteData = wdata;
    end else begin
      busB.MemRead = rd; busB.MemWrite = wr; busB.Addr = addr; busB.WriteData = wdata;
    end
  endtask

  // One complete transaction; with disturb set, Addr/WriteData change and a
  // fresh read request is raised during the wait states
  task automatic runTxn(input string tag, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] expData, input logic expErr,
                        input logic chkData, input logic disturb);
    expect_t e;
    expect_t got;
    int lat;
    int busyCnt;
    bit seen;
    bit extra;
    e.data = expData;
    e.err = expErr;
    e.chkData = chkData;
    e.lat = (curSel == 0) ? WC_A + 1 : WC_B + 1;
    sbQ.push_back(e);
    @(negedge clk);
    applyStimulus(rd, wr, addr, wdata);
    @(posedge clk);
    seen = 0;
    lat = -1;
    busyCnt = 0;
    for (int cyc = 0; cyc < 20 && !seen; cyc++) begin
      @(negedge clk);
      if (obsBusy) busyCnt++;
      if (obsReady) begin
        seen = 1;
        lat = cyc;
      end
      if (cyc == 0) begin
        if (disturb) applyStimulus(1'b1, 1'b0, 32'h34, 32'hFFFF_FFFF);
        else applyStimulus(1'b0, 1'b0, addr, wdata);
      end
      if (cyc == 2 && disturb) applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    end
    got = sbQ.pop_front();
    checkOutput({tag, " ready"}, 32'(seen), 32'd1);
    if (seen) begin
      checkOutput({tag, " latency"}, lat, got.lat);
      checkOutput({tag, " busyCycles"}, busyCnt, got.lat);
      checkOutput({tag, " err"}, 32'(obsErr), 32'(got.err));
      if (got.chkData) checkOutput({tag, " data"}, obsData, got.data);
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (obsReady || obsBusy) extra = 1;
    end
    checkOutput({tag, " quiet"}, 32'(extra), 32'd0);
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Test sequence
  initial begin
    checks = 0;
    errors = 0;
    curSel = 0;
    rst = 1'b1;
    busA.MemRead = 0; busA.MemWrite = 0; busA.Addr = '0; busA.WriteData = '0;
    busB.MemRead = 0; busB.MemWrite = 0; busB.Addr = '0; busB.WriteData = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset ReadData", busA.ReadData, 32'h0);
    checkOutput("reset MemReady", 32'(busA.MemReady), 32'h0);
    checkOutput("reset MemBusy", 32'(busA.MemBusy), 32'h0);
    checkOutput("reset MemErr", 32'(busA.MemErr), 32'h0);
    checkOutput("reset B ReadData", busB.ReadData, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Zero wait states
    curSel = 1;
    runTxn("B wr 0x4", 0, 1, 32'h4, 32'h1234_5678, 32'h0, 0, 1, 0);
    runTxn("B rd 0x4", 1, 0, 32'h4, 32'h0, 32'h1234_5678, 0, 1, 0);

    // Two wait states: basic write/read
    curSel = 0;
    runTxn("wr 0x10", 0, 1, 32'h10, 32'hDEAD_BEEF, 32'h0, 0, 1, 0);
    runTxn("rd 0x10", 1, 0, 32'h10, 32'h0, 32'hDEAD_BEEF, 0, 1, 0);

    // Misaligned accesses are rejected and leave RAM and ReadData alone
    runTxn("wr 0x12 misaligned", 0, 1, 32'h12, 32'h1111_1111, 32'hDEAD_BEEF, 1, 1, 0);
    runTxn("rd 0x6 misaligned", 1, 0, 32'h6, 32'h0, 32'hDEAD_BEEF, 1, 1, 0);
    runTxn("rd 0x10 again", 1, 0, 32'h10, 32'h0, 32'hDEAD_BEEF, 0, 1, 0);

    // Read+write together and out-of-range addresses
    runTxn("wr 0x8", 0, 1, 32'h8, 32'hCAFE_F00D, 32'hDEAD_BEEF, 0, 1, 0);
    runTxn("wr 0x0", 0, 1, 32'h0, 32'h0000_AAAA, 32'hDEAD_BEEF, 0, 1, 0);
    runTxn("rdwr 0x8", 1, 1, 32'h8, 32'h5555_5555, 32'hDEAD_BEEF, 1, 1, 0);
    runTxn("wr 0x400 range", 0, 1, 32'h400, 32'h7777_7777, 32'hDEAD_BEEF, 1, 1, 0);
    runTxn("rd 0x8", 1, 0, 32'h8, 32'h0, 32'hCAFE_F00D, 0, 1, 0);
    runTxn("rd 0x400 range", 1, 0, 32'h400, 32'h0, 32'h0, 1, 1, 0);
    runTxn("rd 0x0", 1, 0, 32'h0, 32'h0, 32'h0000_AAAA, 0, 1, 0);

    // Inputs changed during wait states must not matter
    runTxn("wr 0x34", 0, 1, 32'h34, 32'h2468_ACE0, 32'h0000_AAAA, 0, 1, 0);
    runTxn("wr 0x30 disturbed", 0, 1, 32'h30, 32'h1357_9BDF, 32'h0000_AAAA, 0, 1, 1);
    runTxn("rd 0x30", 1, 0, 32'h30, 32'h0, 32'h1357_9BDF, 0, 1, 0);
    runTxn("rd 0x34", 1, 0, 32'h34, 32'h0, 32'h2468_ACE0, 0, 1, 0);

    // Reset during the wait states of a write
    runTxn("wr 0x20", 0, 1, 32'h20, 32'hA5A5_A5A5, 32'h2468_ACE0, 0, 1, 0);
    runTxn("rd 0x20", 1, 0, 32'h20, 32'h0, 32'hA5A5_A5A5, 0, 1, 0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 32'h20, 32'h5A5A_5A5A);
    @(posedge clk);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("midreset busy before", 32'(obsBusy), 32'd0);
    @(negedge clk);
    checkOutput("midreset busy in wait", 32'(obsBusy), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("midreset ReadData", obsData, 32'h0);
    checkOutput("midreset MemReady", 32'(obsReady), 32'h0);
    checkOutput("midreset MemBusy", 32'(obsBusy), 32'h0);
    checkOutput("midreset MemErr", 32'(obsErr), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    begin
      bit sawReady;
      sawReady = 0;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        if (obsReady) sawReady = 1;
      end
      checkOutput("midreset no ready", 32'(sawReady), 32'd0);
    end
    runTxn("rd 0x20 after reset", 1, 0, 32'h20, 32'h0, 32'hA5A5_A5A5, 0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
